npc_gen: RTL and testbench

Parametrised next-PC generator for the pipelined MIPS core. It owns the fetch PC register and computes branch, jump (region-concatenated) and jump-register targets from D-stage operands. Redirects arriving under a stall are buffered until the stall releases. Exception entry and `eret` take absolute priority. It sits between the F-stage IM address and the D-stage branch/jump decode.

---
 rtl/npc_pkg.sv | 24 ++
 rtl/npc_target_calc.sv | 40 ++++
 rtl/npc_gen.sv | 87 ++++++++
 tb/tb_npc_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | npc_pkg : shared types and default addresses for the next-PC generator     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package npc_pkg;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    J    = 2'd1,
    JR   = 2'd2,
    RSVD = 2'd3
  } redir_kind_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } npc_state_t;

  localparam logic [31:0] c_reset_pc = 32'h0000_3000;
  localparam logic [31:0] c_exc_vec  = 32'h0000_4180;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_target_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | npc_target_calc : combinational branch / jump / jump-register target       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module npc_target_calc
  import npc_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int REGION_W = 4
) (
  input  redir_kind_t                       kind,
  input  logic [ADDR_W-1:0]                 redir_pc,
  input  logic [15:0]                       imm16,
  input  logic [ADDR_W-REGION_W-3:0]        imm_j,
  input  logic [ADDR_W-1:0]                 reg_target,
  output logic [ADDR_W-1:0]                 target,
  output logic                              valid
);

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_br_off;

  assign w_pc4    = redir_pc + ADDR_W'(4);
  assign w_br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // J-type region comes from the delay-slot PC, not the jump itself
  always_comb begin
    target = '0;
    valid  = 1'b1;
    case (kind)
      BR:      target = w_pc4 + w_br_off;
      J:       target = {w_pc4[ADDR_W-1 -: REGION_W], imm_j, 2'b00};
      JR:      target = reg_target;
      default: valid  = 1'b0;
    endcase
  end

endmodule : npc_target_calc
`default_nettype wire

// File: rtl/npc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | npc_gen : fetch PC register with stall-buffered redirects and exceptions   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module npc_gen
  import npc_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 REGION_W = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(c_reset_pc),
  parameter logic [ADDR_W-1:0]  EXC_VEC  = ADDR_W'(c_exc_vec)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic                              redir_valid,
  input  logic [1:0]                        redir_kind,
  input  logic [ADDR_W-1:0]                 redir_pc,
  input  logic [15:0]                       imm16,
  input  logic [ADDR_W-REGION_W-3:0]        imm_j,
  input  logic [ADDR_W-1:0]                 reg_target,
  input  logic                              exc_req,
  input  logic                              eret_req,
  input  logic [ADDR_W-1:0]                 epc,
  output logic [ADDR_W-1:0]                 pc,
  output logic [ADDR_W-1:0]                 pc_plus8,
  output logic                              pending,
  output logic                              fetch_adel
);

  npc_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_held_tgt;
  logic [ADDR_W-1:0] w_target;
  logic              w_kind_ok;
  logic              w_take;

  npc_target_calc #(
    .ADDR_W   (ADDR_W),
    .REGION_W (REGION_W)
  ) u_target_calc (
    .kind       (redir_kind_t'(redir_kind)),
    .redir_pc   (redir_pc),
    .imm16      (imm16),
    .imm_j      (imm_j),
    .reg_target (reg_target),
    .target     (w_target),
    .valid      (w_kind_ok)
  );

  assign w_take = redir_valid & w_kind_ok;

  // Exception and eret override the stall; a held target beats a fresh redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_state    <= RUN;
      r_held_tgt <= '0;
    end else if (exc_req) begin
      r_pc    <= EXC_VEC;
      r_state <= RUN;
    end else if (eret_req) begin
      r_pc    <= epc;
      r_state <= RUN;
    end else if (stall) begin
      if (r_state == RUN && w_take) begin
        r_held_tgt <= w_target;
        r_state    <= HOLD;
      end
    end else if (r_state == HOLD) begin
      r_pc    <= r_held_tgt;
      r_state <= RUN;
    end else if (w_take) begin
      r_pc <= w_target;
    end else begin
      r_pc <= r_pc + ADDR_W'(4);
    end
  end

  assign pc         = r_pc;
  assign pending    = (r_state == HOLD);
  assign pc_plus8   = redir_pc + ADDR_W'(8);
  assign fetch_adel = (r_pc[1:0] != 2'b00);

endmodule : npc_gen
`default_nettype wire

// File: tb/tb_npc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_npc_gen : directed + random self-checking bench for npc_gen             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_npc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc;
  logic [15:0] imm16;
  logic [25:0] imm_j;
  logic [31:0] reg_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        pending;
  logic        fetch_adel;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_held;

  npc_gen dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_pc    (redir_pc),
    .imm16       (imm16),
    .imm_j       (imm_j),
    .reg_target  (reg_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc          (pc),
    .pc_plus8    (pc_plus8),
    .pending     (pending),
    .fetch_adel  (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] rpc,
                                               input logic [15:0] off, input logic [25:0] idx,
                                               input logic [31:0] rt);
    int signed soff;
    soff = $signed(off);
    case (k)
      2'd0:    return rpc + 32'd4 + 32'(soff * 4);
      2'd1:    return ((rpc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
      default: return rt;
    endcase
  endfunction

  task automatic model_edge();
    bit          redir_ok;
    logic [31:0] t;
    redir_ok = redir_valid && (redir_kind != 2'd3);
    t = model_target(redir_kind, redir_pc, imm16, imm_j, reg_target);
    if (exc_req) begin
      m_pc = 32'h0000_4180; m_held = 0;
    end else if (eret_req) begin
      m_pc = epc; m_held = 0;
    end else if (stall) begin
      if (!m_held && redir_ok) begin
        m_held = 1; m_tgt = t;
      end
    end else if (m_held) begin
      m_pc = m_tgt; m_held = 0;
    end else if (redir_ok) begin
      m_pc = t;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    stall = 0; redir_valid = 0; redir_kind = 0; redir_pc = 0; imm16 = 0;
    imm_j = 0; reg_target = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic redir(input logic [1:0] k, input logic [31:0] rpc, input logic [15:0] off,
                       input logic [25:0] idx, input logic [31:0] rt);
    redir_valid = 1; redir_kind = k; redir_pc = rpc; imm16 = off; imm_j = idx; reg_target = rt;
  endtask

  // one clock edge, then compare DUT against the model
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("pc", pc, m_pc);
    check_val("pending", 32'(pending), 32'(m_held));
    check_val("fetch_adel", 32'(fetch_adel), 32'(m_pc[1:0] != 2'b00));
  endtask

  logic [31:0] frozen;

  initial begin
    idle();
    reset = 1;
    m_pc = 32'h3000; m_held = 0; m_tgt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_val("reset_pc", pc, 32'h3000);
    check_val("reset_pending", 32'(pending), 32'd0);

    tick(); check_val("free1", pc, 32'h3004);
    tick(); check_val("free2", pc, 32'h3008);
    tick(); check_val("free3", pc, 32'h300C);

    redir(2'd0, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    #1 check_val("pc_plus8", pc_plus8, 32'h3018);
    tick(); check_val("br_target", pc, 32'h3004);
    redir(2'd1, 32'h3FFF_FFFC, 16'd0, 26'h10, 32'd0);
    tick(); check_val("j_region", pc, 32'h4000_0040);

    frozen = pc;
    idle(); stall = 1; redir(2'd2, 32'h3000, 16'd0, 26'd0, 32'h3100);
    tick(); check_val("stall_frozen1", pc, frozen);
    check_val("stall_pending", 32'(pending), 32'd1);
    redir(2'd2, 32'h3000, 16'd0, 26'd0, 32'h3200);
    tick(); check_val("stall_frozen2", pc, frozen);
    redir_valid = 0;
    tick(); check_val("stall_frozen3", pc, frozen);
    stall = 0;
    tick(); check_val("stall_release", pc, 32'h3100);
    check_val("release_pending", 32'(pending), 32'd0);

    stall = 1; redir(2'd2, 32'h3000, 16'd0, 26'd0, 32'h3300);
    tick();
    redir_valid = 0; exc_req = 1;
    tick(); check_val("exc_in_hold", pc, 32'h4180);
    check_val("exc_pending", 32'(pending), 32'd0);
    exc_req = 0; eret_req = 1; epc = 32'h3008; stall = 0;
    tick(); check_val("eret", pc, 32'h3008);
    eret_req = 0; exc_req = 1; eret_req = 1;
    tick(); check_val("exc_over_eret", pc, 32'h4180);
    idle();

    redir(2'd2, 32'h3000, 16'd0, 26'd0, 32'h3002);
    tick(); check_val("jr_misaligned", pc, 32'h3002);
    check_val("adel1", 32'(fetch_adel), 32'd1);
    idle();
    tick(); check_val("misaligned_inc", pc, 32'h3006);
    check_val("adel2", 32'(fetch_adel), 32'd1);

    stall = 1; redir(2'd2, 32'h3000, 16'd0, 26'd0, 32'h3400);
    tick();
    idle(); stall = 1;
    #2 reset = 1;
    #1;
    m_pc = 32'h3000; m_held = 0; m_tgt = 0;
    check_val("async_reset_pc", pc, 32'h3000);
    check_val("async_reset_pending", 32'(pending), 32'd0);
    #2 reset = 0; stall = 0;
    tick(); check_val("held_discarded", pc, 32'h3004);

    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redir_valid = ($urandom_range(0, 9) < 4);
      redir_kind  = 2'($urandom_range(0, 3));
      redir_pc    = $urandom;
      imm16       = 16'($urandom);
      imm_j       = 26'($urandom);
      reg_target  = $urandom;
      exc_req     = ($urandom_range(0, 31) == 0);
      eret_req    = ($urandom_range(0, 31) == 0);
      epc         = $urandom;
      #1 check_val("rnd_pc_plus8", pc_plus8, redir_pc + 32'd8);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_npc_gen
`default_nettype wire
